// File: rtl/fp_pkg.sv
// Shared constants and types for the float-to-integer conversion path.
package fp_pkg;

   localparam int unsigned EXP_BIAS   = 127;
   localparam int unsigned FRAC_W     = 23;
   localparam int unsigned SIG_W      = 24;
   localparam int unsigned SHIFT_BASE = 150;
   localparam int unsigned SHAMT_W    = 5;
   localparam int unsigned FLAGS_W    = 5;

   // Bit positions inside out_flags.
   localparam int unsigned FLAG_INVALID  = 4;
   localparam int unsigned FLAG_OVERFLOW = 3;
   localparam int unsigned FLAG_INEXACT  = 2;
   localparam int unsigned FLAG_ZERO     = 1;
   localparam int unsigned FLAG_SIGN     = 0;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      SHIFT,
      PACK,
      HOLD
   } state_t;

   typedef enum logic [1:0] {
      NORMAL,
      SMALL,
      SAT,
      INVALID
   } class_t;

endpackage

// File: rtl/shift_right.sv
// Sign-magnitude significand right shifter.
// in_sig : {sign, hidden, fraction}; sign passes through, the 24-bit
//          significand is shifted right by nshift, shifted-out bits dropped.
// nshift : shift count 0..31.
// out_sig: {sign, shifted significand}.
module shift_right
   import fp_pkg::*;
(
   input  logic [SIG_W:0]        in_sig,
   input  logic [SHAMT_W-1:0]    nshift,
   output logic [SIG_W:0]        out_sig
);

   assign out_sig = {in_sig[SIG_W], in_sig[SIG_W-1:0] >> nshift};

endmodule

// File: rtl/fp2int_ctrl.sv
// Sequenced IEEE754 single to 32-bit signed integer conversion (truncate).
// clk, rst_n     : clock, synchronous active-low reset.
// in_valid/ready : operand handshake, in_fp is the float operand.
// out_valid/ready: result handshake, out_int result, out_flags
//                  {invalid, overflow, inexact, zero, sign}.
module fp2int_ctrl
   import fp_pkg::*;
#(
   parameter logic [31:0] SAT_POS = 32'h7FFF_FFFF,
   parameter logic [31:0] SAT_NEG = 32'h8000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_fp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_int,
   output logic [FLAGS_W-1:0]   out_flags
);

   state_t               state_q, state_d;
   class_t               cls_q, cls_d;
   logic [31:0]          fp_q, fp_d;
   logic [SIG_W:0]       op_q, op_d;
   logic [SHAMT_W-1:0]   sh_q, sh_d;
   logic [SIG_W:0]       res_q, res_d;
   logic                 inexact_q, inexact_d;
   logic [31:0]          out_int_q, out_int_d;
   logic [FLAGS_W-1:0]   out_flags_q, out_flags_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   logic [SIG_W:0]       shift_out;

   shift_right u_shift (
      .in_sig  (op_q),
      .nshift  (sh_q),
      .out_sig (shift_out)
   );

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cls_q       <= NORMAL;
         fp_q        <= '0;
         op_q        <= '0;
         sh_q        <= '0;
         res_q       <= '0;
         inexact_q   <= 1'b0;
         out_int_q   <= '0;
         out_flags_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         fp_q        <= fp_d;
         op_q        <= op_d;
         sh_q        <= sh_d;
         res_q       <= res_d;
         inexact_q   <= inexact_d;
         out_int_q   <= out_int_d;
         out_flags_q <= out_flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      logic [7:0]         e;
      logic [FRAC_W-1:0]  f;
      logic [FRAC_W-1:0]  mask;
      logic               sgn;
      logic [FLAGS_W-1:0] flags;
      logic [31:0]        val;

      state_d     = state_q;
      cls_d       = cls_q;
      fp_d        = fp_q;
      op_d        = op_q;
      sh_d        = sh_q;
      res_d       = res_q;
      inexact_d   = inexact_q;
      out_int_d   = out_int_q;
      out_flags_d = out_flags_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      e     = fp_q[30:23];
      f     = fp_q[FRAC_W-1:0];
      // Bits of the fraction that fall off the end for a shift of sh_q.
      mask  = FRAC_W'((SIG_W'(1) << sh_q) - SIG_W'(1));
      sgn   = res_q[SIG_W];
      flags = '0;
      val   = '0;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               fp_d       = in_fp;
               in_ready_d = 1'b0;
               state_d    = DECODE;
            end
         end

         DECODE: begin
            op_d = {fp_q[31], (e != 8'd0), f};
            sh_d = '0;
            if (e == 8'hFF) begin
               cls_d = (f != '0) ? INVALID : SAT;
            end else if (e > 8'(SHIFT_BASE)) begin
               cls_d = SAT;
            end else if (e < 8'(EXP_BIAS)) begin
               cls_d = SMALL;
            end else begin
               cls_d = NORMAL;
               sh_d  = SHAMT_W'(8'(SHIFT_BASE) - e);
            end
            state_d = SHIFT;
         end

         SHIFT: begin
            res_d = shift_out;
            // Shifter drops the low bits, so inexact is taken from the operand.
            case (cls_q)
               NORMAL:  inexact_d = |(op_q[FRAC_W-1:0] & mask);
               SMALL:   inexact_d = |op_q[SIG_W-1:0];
               default: inexact_d = 1'b0;
            endcase
            state_d = PACK;
         end

         PACK: begin
            case (cls_q)
               NORMAL: begin
                  val = sgn ? (32'd0 - {8'd0, res_q[SIG_W-1:0]})
                            : {8'd0, res_q[SIG_W-1:0]};
                  flags[FLAG_INEXACT] = inexact_q;
               end
               SMALL: begin
                  val = '0;
                  flags[FLAG_INEXACT] = inexact_q;
               end
               SAT: begin
                  val = sgn ? SAT_NEG : SAT_POS;
                  flags[FLAG_OVERFLOW] = 1'b1;
               end
               default: begin
                  val = '0;
                  flags[FLAG_INVALID] = 1'b1;
               end
            endcase
            flags[FLAG_ZERO] = (val == 32'd0);
            flags[FLAG_SIGN] = sgn;
            out_int_d   = val;
            out_flags_d = flags;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end

         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_int   = out_int_q;
   assign out_flags = out_flags_q;

endmodule

// File: doc/fp2int_ctrl.md
Name: fp2int_ctrl

Overview:
- Multi-cycle sequencer that converts one IEEE754 single-precision operand to a 32-bit two's-complement integer, truncating toward zero.
- Decodes the float, computes the right-shift count, and drives the team's existing 24-bit significand right-shifter (sign bit + hidden 1 + 23-bit fraction).
- Registers the shifter result, then applies sign, saturation and flags.
- Sits between the FP-to-decimal front end and the display/decimal-digit stage, with valid/ready handshakes on both sides.

Parameters:
- SAT_POS, 32'h7FFF_FFFF, result driven on positive overflow or +Inf.
- SAT_NEG, 32'h8000_0000, result driven on negative overflow or -Inf.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  in_fp holds an operand.
- in_ready  output  1  block can accept an operand.
- in_fp  input  32  IEEE754 single: [31] sign, [30:23] exponent, [22:0] fraction.
- out_valid  output  1  out_int/out_flags valid.
- out_ready  input  1  consumer accepts the result.
- out_int  output  32  signed integer result.
- out_flags  output  5  [4] invalid, [3] overflow, [2] inexact, [1] zero, [0] sign.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_int=0, out_flags=0. Reset mid-operation discards the operand; no result is produced.
- FSM states: IDLE -> DECODE -> SHIFT -> PACK -> HOLD -> IDLE.
- IDLE: in_ready=1 only in this state. A handshake (in_valid&&in_ready) latches in_fp and moves to DECODE.
- DECODE: e=exp, f=fraction. Classify and register class plus the shifter operand {sign, hidden, f} with hidden=(e!=0).
  - e=255, f!=0 (NaN): class INVALID.
  - e=255, f=0 (Inf): class SAT.
  - e>150: class SAT (overflow).
  - e<127, including zero and denormals: class SMALL.
  - otherwise: class NORMAL, sh=150-e (range 0..23, 5 bits).
- SHIFT: shifter input is {sign, hidden, f} with nshift=sh. Register the shifter output, mag=out[23:0].
  - Inexact for NORMAL = (f & ((1<<sh)-1)) != 0. Computed here from the mask, because the shifter discards shifted-out bits.
  - Non-NORMAL classes pass through this state; the shifter result is ignored.
- PACK: load out_int/out_flags, assert out_valid next edge, enter HOLD.
  - NORMAL: out_int = sign ? -{8'b0,mag} : {8'b0,mag}.
  - SMALL: out_int=0; inexact=(e!=0)||(f!=0); zero=1.
  - SAT: out_int = sign ? SAT_NEG : SAT_POS; overflow=1.
  - INVALID: out_int=0; invalid=1; zero=1.
  - Flag zero=1 whenever out_int==0. Flag sign = input sign bit, for every class (so -0.0 gives zero=1, sign=1).
- HOLD: out_valid=1; out_int and out_flags stable while out_ready=0, for any number of cycles. On out_ready=1, go to IDLE and drop out_valid on the same edge.
- Latency: handshake edge at cycle 0 -> out_valid high after edge 4 (cycle 4). Throughput is one operand per 5 cycles with no backpressure.
- No overlap: in_ready stays 0 from the accept edge until the cycle after the output handshake. in_valid while busy is ignored and not latched.
- Magnitude is exact for |x| < 2^24. 2^24 and larger saturate by decision.

Decomposition:
- Shared package fp_pkg:
  - localparams EXP_BIAS=127, FRAC_W=23, SIG_W=24, SHIFT_BASE=150.
  - enum state_t {IDLE, DECODE, SHIFT, PACK, HOLD}.
  - enum class_t {NORMAL, SMALL, SAT, INVALID}.
  - flag bit index constants.
- Sub-module: instantiate the existing shift_right (25-bit in, 5-bit nshift) once; do not duplicate it. All other logic stays in fp2int_ctrl.

Test Plan:
- 0x3F800000 (1.0), out_ready=1 -> out_valid at cycle 4; out_int=0x00000001, flags=5'b00000.
- 0xC0B80000 (-5.75) -> out_int=0xFFFFFFFB, flags=5'b00101 (inexact, sign).
- 0x4B7FFFFF (16777215.0) -> out_int=0x00FFFFFF, flags=0. Then 0x4B800000 (2^24) -> 0x7FFFFFFF, flags=5'b01000. Then 0xFF800000 (-Inf) -> 0x80000000, flags=5'b01001.
- 0x7FC00000 (NaN) -> out_int=0, flags=5'b10010. 0x3F000000 (0.5) -> 0, flags=5'b00110. 0x80000000 (-0.0) -> 0, flags=5'b00011.
- Backpressure: out_ready=0 for 7 cycles after out_valid. Result holds stable, in_ready=0, a second in_valid is ignored. out_ready=1 -> IDLE, in_ready=1 on the next cycle.
- rst_n=0 at the SHIFT cycle -> next cycle out_valid=0, in_ready=1, out_int=0. The dropped operand never appears at the output.
